// File: rtl/nnrv_dmem_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nnrv_dmem_if : load/store port and TX byte stream bundle for nnrv_dmem
// Revision 1.0
// ----------------------------------------------------------------------------
interface nnrv_dmem_if #(
  parameter int XLEN = 32
);
  logic            i_ram_rd_en;
  logic [XLEN-1:0] i_ram_rd_addr;
  logic [3:0]      i_ram_rd_mask;
  logic [XLEN-1:0] o_ram_rd_data;
  logic            i_ram_wr_en;
  logic [XLEN-1:0] i_ram_wr_addr;
  logic [3:0]      i_ram_wr_mask;
  logic [XLEN-1:0] i_ram_wr_data;
  logic            o_tx_valid;
  logic [7:0]      o_tx_data;
  logic            i_tx_ready;
  logic            o_misaligned;

  modport slave (
    input  i_ram_rd_en, i_ram_rd_addr, i_ram_rd_mask,
    output o_ram_rd_data,
    input  i_ram_wr_en, i_ram_wr_addr, i_ram_wr_mask, i_ram_wr_data,
    output o_tx_valid, o_tx_data,
    input  i_tx_ready,
    output o_misaligned
  );

  modport master (
    output i_ram_rd_en, i_ram_rd_addr, i_ram_rd_mask,
    input  o_ram_rd_data,
    output i_ram_wr_en, i_ram_wr_addr, i_ram_wr_mask, i_ram_wr_data,
    input  o_tx_valid, o_tx_data,
    output i_tx_ready,
    input  o_misaligned
  );
endinterface
`default_nettype wire

// File: rtl/nnrv_dmem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// nnrv_dmem : zero-latency data RAM with MMIO TX FIFO and cycle counter
// Revision 1.0
// ----------------------------------------------------------------------------
module nnrv_dmem #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE   = 32'h1000_0000,
  parameter int              FIFO_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  nnrv_dmem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  function automatic logic legal(input logic [3:0] m);
    return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  function automatic logic [XLEN-1:0] lanes(input logic [3:0] m);
    logic [XLEN-1:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

  logic [XLEN-1:0] mem_q [DEPTH_WORDS];
  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] cycle_q, cycle_d;

  logic            w_rd_ok, w_wr_ok, w_rd_mmio, w_wr_mmio;
  logic [1:0]      w_rd_reg, w_wr_reg;
  logic [AW-1:0]   w_rd_idx, w_wr_idx;
  logic [XLEN-1:0] w_wr_lanes, w_rd_raw, w_status;
  logic            w_full, w_empty, w_pop, w_push_req, w_push, w_ovf_clr, w_cyc_wr;
  logic            w_unused_addr;

  assign w_rd_ok   = bus.i_ram_rd_en && legal(bus.i_ram_rd_mask);
  assign w_wr_ok   = bus.i_ram_wr_en && legal(bus.i_ram_wr_mask);
  assign w_rd_mmio = bus.i_ram_rd_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign w_wr_mmio = bus.i_ram_wr_addr[XLEN-1:4] == MMIO_BASE[XLEN-1:4];
  assign w_rd_reg  = bus.i_ram_rd_addr[3:2];
  assign w_wr_reg  = bus.i_ram_wr_addr[3:2];
  assign w_rd_idx  = bus.i_ram_rd_addr[AW+1:2];
  assign w_wr_idx  = bus.i_ram_wr_addr[AW+1:2];
  assign w_wr_lanes = lanes(bus.i_ram_wr_mask);
  assign w_unused_addr = ^{bus.i_ram_rd_addr[1:0], bus.i_ram_wr_addr[1:0]};

  assign bus.o_misaligned = (bus.i_ram_rd_en && !legal(bus.i_ram_rd_mask)) ||
                            (bus.i_ram_wr_en && !legal(bus.i_ram_wr_mask));

  assign w_full  = count_q == CW'(FIFO_DEPTH);
  assign w_empty = count_q == '0;

  always_comb begin
    w_status          = '0;
    w_status[0]       = w_full;
    w_status[1]       = w_empty;
    w_status[2]       = ovf_q;
    w_status[8 +: CW] = count_q;
  end

  always_comb begin
    w_rd_raw = '0;
    if (w_rd_mmio) begin
      case (w_rd_reg)
        2'd1:    w_rd_raw = w_status;
        2'd2:    w_rd_raw = cycle_q;
        default: w_rd_raw = '0;
      endcase
    end else begin
      w_rd_raw = mem_q[w_rd_idx];
    end
  end

  assign bus.o_ram_rd_data = w_rd_ok ? (w_rd_raw & lanes(bus.i_ram_rd_mask)) : '0;

  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign w_pop      = !w_empty && bus.i_tx_ready;
  assign w_push_req = w_wr_ok && w_wr_mmio && (w_wr_reg == 2'd0) && bus.i_ram_wr_mask[0];
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_clr  = w_wr_ok && w_wr_mmio && (w_wr_reg == 2'd1) &&
                      bus.i_ram_wr_mask[0] && bus.i_ram_wr_data[2];
  assign w_cyc_wr   = w_wr_ok && w_wr_mmio && (w_wr_reg == 2'd2);

  always_comb begin
    count_d = count_q + CW'(w_push) - CW'(w_pop);
    ovf_d   = ovf_q;
    if (w_push_req && !w_push) ovf_d = 1'b1;
    else if (w_ovf_clr)        ovf_d = 1'b0;
    cycle_d = w_cyc_wr ? ((cycle_q & ~w_wr_lanes) | (bus.i_ram_wr_data & w_wr_lanes))
                       : cycle_q + 1'b1;
  end

  // RAM is not reset, so stores commit even while i_rst is high.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !w_wr_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.i_ram_wr_mask[b]) mem_q[w_wr_idx][8*b +: 8] <= bus.i_ram_wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      cycle_q <= '0;
    end else begin
      if (w_push) begin
        fifo_q[wptr_q] <= bus.i_ram_wr_data[7:0];
        wptr_q         <= wptr_q + 1'b1;
      end
      if (w_pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      cycle_q <= cycle_d;
    end
  end

  assign bus.o_tx_valid = !w_empty;
  assign bus.o_tx_data  = w_empty ? 8'h00 : fifo_q[rptr_q];
endmodule
`default_nettype wire

// File: tb/tb_nnrv_dmem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_nnrv_dmem : scoreboard bench for nnrv_dmem against a queue/array model
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_nnrv_dmem;
  localparam int          DEPTH = 1024;
  localparam int          FD    = 8;
  localparam logic [31:0] MB    = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nnrv_dmem_if #(.XLEN(32)) bus ();

  nnrv_dmem #(.XLEN(32), .DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .FIFO_DEPTH(FD)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    logic        vld;
    logic [7:0]  dat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: word array, byte queue, sticky flag, counter.
  logic [31:0] mram [DEPTH];
  logic [7:0]  mq[$];
  bit          movf = 0;
  logic [31:0] mcyc = 0;

  function automatic bit is_legal(input logic [3:0] m);
    return m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  endfunction

  function automatic logic [31:0] lanemask(input logic [3:0] m);
    logic [31:0] r = 0;
    for (int b = 0; b < 4; b++) if (m[b]) r = r | (32'hFF << (8 * b));
    return r;
  endfunction

  function automatic bit is_mmio(input logic [31:0] a);
    return (a >> 4) == (MB >> 4);
  endfunction

  function automatic logic [31:0] mstatus();
    logic [31:0] s;
    s = (mq.size() == FD) ? 32'd1 : 32'd0;
    if (mq.size() == 0) s = s + 2;
    if (movf) s = s + 4;
    return s + (mq.size() * 256);
  endfunction

  function automatic logic [31:0] mread(input bit en, input logic [31:0] a, input logic [3:0] m);
    logic [31:0] w;
    int          r;
    if (!en || !is_legal(m)) return 0;
    r = (a >> 2) % 4;
    if (is_mmio(a)) w = (r == 1) ? mstatus() : (r == 2) ? mcyc : 32'd0;
    else            w = mram[(a >> 2) % DEPTH];
    return w & lanemask(m);
  endfunction

  function automatic void mstep(input bit r, input bit we, input logic [31:0] a,
                                input logic [3:0] m, input logic [31:0] d, input bit rdy);
    bit          wok = we && is_legal(m);
    int          reg_n = (a >> 2) % 4;
    logic [31:0] lm = lanemask(m);
    bit          cyc_written = 0;
    if (wok && !is_mmio(a)) mram[(a >> 2) % DEPTH] = (mram[(a >> 2) % DEPTH] & ~lm) | (d & lm);
    if (r) begin
      mq.delete();
      movf = 0;
      mcyc = 0;
      return;
    end
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (wok && is_mmio(a)) begin
      if (reg_n == 0 && m[0]) begin
        if (mq.size() < FD) mq.push_back(d[7:0]);
        else movf = 1;
      end else if (reg_n == 1 && m[0] && d[2]) begin
        movf = 0;
      end else if (reg_n == 2) begin
        mcyc = (mcyc & ~lm) | (d & lm);
        cyc_written = 1;
      end
    end
    if (!cyc_written) mcyc = mcyc + 1;
  endfunction

  task automatic cyc(input bit r, input bit re, input logic [31:0] ra, input logic [3:0] rm,
                     input bit we, input logic [31:0] wa, input logic [3:0] wm,
                     input logic [31:0] wd, input bit rdy);
    exp_t e;
    @(negedge clk);
    rst               = r;
    bus.i_ram_rd_en   = re;
    bus.i_ram_rd_addr = ra;
    bus.i_ram_rd_mask = rm;
    bus.i_ram_wr_en   = we;
    bus.i_ram_wr_addr = wa;
    bus.i_ram_wr_mask = wm;
    bus.i_ram_wr_data = wd;
    bus.i_tx_ready    = rdy;
    e.rd  = mread(re, ra, rm);
    e.mis = (re && !is_legal(rm)) || (we && !is_legal(wm));
    e.vld = mq.size() > 0;
    e.dat = e.vld ? mq[0] : 8'h00;
    sb.push_back(e);
    mstep(r, we, wa, wm, wd, rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic [3:0] m, input bit rdy);
    cyc(0, 1, a, m, 0, 0, 0, 0, rdy);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, input bit rdy);
    cyc(0, 0, 0, 0, 1, a, m, d, rdy);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_tests++;
        if (bus.o_ram_rd_data !== e.rd || bus.o_misaligned !== e.mis ||
            bus.o_tx_valid !== e.vld || bus.o_tx_data !== e.dat) begin
          n_fail++;
          $display("FAIL resp@%0t: got rd=%h mis=%b vld=%b dat=%h, want rd=%h mis=%b vld=%b dat=%h",
                   $time, bus.o_ram_rd_data, bus.o_misaligned, bus.o_tx_valid, bus.o_tx_data,
                   e.rd, e.mis, e.vld, e.dat);
        end
      end
    end
  end

  function automatic logic [31:0] raddr();
    if ($urandom_range(0, 3) == 0) return MB | 32'($urandom_range(0, 15));
    return ($urandom & 32'h0FFF_F000) | 32'($urandom_range(0, 39) << 2) | 32'($urandom_range(0, 3));
  endfunction

  function automatic logic [3:0] rmask();
    logic [3:0] legal_m [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    if ($urandom_range(0, 99) < 85) return legal_m[$urandom_range(0, 6)];
    return 4'($urandom_range(0, 15));
  endfunction

  initial begin : stim
    bus.i_ram_rd_en = 0; bus.i_ram_rd_addr = 0; bus.i_ram_rd_mask = 0;
    bus.i_ram_wr_en = 0; bus.i_ram_wr_addr = 0; bus.i_ram_wr_mask = 0;
    bus.i_ram_wr_data = 0; bus.i_tx_ready = 0;
    repeat (2) @(posedge clk);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rd(MB | 32'h4, 4'hF, 0);
    for (int i = 0; i < 40; i++) wr(32'(i * 4), 4'hF, $urandom, 0);

    // Word, halfword and byte lane reads and a same-cycle read during a byte store.
    wr(32'h40, 4'hF, 32'hDEADBEEF, 0);
    rd(32'h40, 4'hF, 0);
    rd(32'h41, 4'b0010, 0);
    rd(32'h42, 4'b1100, 0);
    cyc(0, 1, 32'h40, 4'hF, 1, 32'h42, 4'b0100, 32'h00AA_0000, 0);
    rd(32'h40, 4'hF, 0);

    for (int i = 1; i <= 9; i++) wr(MB, 4'b0001, 32'(i), 0);
    rd(MB | 32'h4, 4'hF, 0);
    for (int i = 0; i < 9; i++) rd(MB | 32'h4, 4'hF, 1);
    wr(MB | 32'h4, 4'b0001, 32'h4, 0);
    rd(MB | 32'h4, 4'hF, 0);

    for (int i = 0; i < 8; i++) wr(MB, 4'b0001, 32'(8'h10 + i), 0);
    wr(MB, 4'b0001, 32'h55, 1);
    rd(MB | 32'h4, 4'hF, 0);
    for (int i = 0; i < 8; i++) rd(MB | 32'h4, 4'hF, 1);

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) rd(MB | 32'h8, 4'hF, 0);
    wr(MB | 32'h8, 4'hF, 32'hFFFF_FFFE, 0);
    for (int i = 0; i < 3; i++) rd(MB | 32'h8, 4'hF, 0);
    wr(MB | 32'h8, 4'b0010, 32'h0000_1200, 0);
    rd(MB | 32'h8, 4'hF, 0);

    wr(32'h80, 4'b0110, 32'h1234_5678, 0);
    rd(32'h80, 4'hF, 0);
    rd(32'h80, 4'b0101, 0);
    rd(MB | 32'h0, 4'hF, 0);
    rd(MB | 32'hC, 4'hF, 0);

    for (int i = 0; i < 4; i++) wr(MB, 4'b0001, 32'(8'hA0 + i), 0);
    rd(MB | 32'h4, 4'hF, 1);
    cyc(1, 0, 0, 0, 1, MB, 4'b0001, 32'h77, 1);
    rd(MB | 32'h4, 4'hF, 1);
    cyc(1, 0, 0, 0, 1, 32'h44, 4'hF, 32'hCAFE_F00D, 0);
    rd(32'h44, 4'hF, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] wa;
      bit          we;
      we = $urandom_range(0, 99) < 60;
      wa = ($urandom_range(0, 2) == 0) ? MB : raddr();
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 99) < 70, raddr(), rmask(),
          we, wa, rmask(), $urandom, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d responses left unchecked, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
